cp0_regfile: RTL and testbench

//  MIPS32 CP0 register file, directly downstream of the writeback-stage exception unit.

---
 rtl/cp0_pkg.sv | 56 +++++
 rtl/cp0_timer.sv | 55 +++++
 rtl/cp0_regfile.sv | 152 +++++++++++++++
 tb/tb_cp0_regfile.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause bit positions,
// ExcCode values and the software write mask for Status.
package cp0_pkg;

   // CP0 register numbers (select 0)
   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   // Status bit positions
   localparam int unsigned STATUS_IE    = 0;
   localparam int unsigned STATUS_EXL   = 1;
   localparam int unsigned STATUS_IM_LO = 8;
   localparam int unsigned STATUS_IM_HI = 15;
   localparam int unsigned STATUS_BEV   = 22;

   // Cause bit positions
   localparam int unsigned CAUSE_EXC_LO = 2;
   localparam int unsigned CAUSE_EXC_HI = 6;
   localparam int unsigned CAUSE_IP_LO  = 8;
   localparam int unsigned CAUSE_IP_HI  = 15;
   localparam int unsigned CAUSE_TI     = 30;
   localparam int unsigned CAUSE_BD     = 31;

   // ExcCode values
   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0a;
   localparam logic [4:0] EXC_OV   = 5'h0c;

   // Software-writable Status bits: IM[15:8], EXL, IE
   localparam logic [31:0] STATUS_WMASK    = 32'h0000_ff03;
   // BEV always reads back as its reset value
   localparam logic [31:0] STATUS_BEV_MASK = 32'h0040_0000;

   // Assemble the architectural Cause word from its stored fields
   function automatic logic [31:0] pack_cause(input logic       bd,
                                              input logic       ti,
                                              input logic [7:0] ip,
                                              input logic [4:0] exc);
      logic [31:0] c;
      c = '0;
      c[CAUSE_BD]                   = bd;
      c[CAUSE_TI]                   = ti;
      c[CAUSE_IP_HI:CAUSE_IP_LO]    = ip;
      c[CAUSE_EXC_HI:CAUSE_EXC_LO]  = exc;
      return c;
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaler, free-running Count, Compare and the
// sticky timer interrupt flag TI.
module cp0_timer #(
   parameter int COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(COUNT_DIV - 1);

   logic [DIV_W-1:0] div_q;
   logic             div_wrap;

   assign div_wrap = (div_q == DIV_MAX);

   // Prescaler and Count; a software load restarts the prescaler and
   // suppresses the increment for that cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
         count <= '0;
      end else if (count_we) begin
         div_q <= '0;
         count <= wdata;
      end else if (div_wrap) begin
         div_q <= '0;
         count <= count + 32'd1;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

   // Compare register and sticky TI; writing Compare clears TI even if the
   // current Count matches in the same cycle. Compare==0 never matches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         compare <= '0;
         ti      <= 1'b0;
      end else if (compare_we) begin
         compare <= wdata;
         ti      <= 1'b0;
      end else if ((count == compare) && (compare != 32'd0)) begin
         ti      <= 1'b1;
      end
   end

endmodule

// File: rtl/cp0_regfile.sv
// MIPS32 CP0 register file: exception commit, ERET, MTC0/MFC0, interrupt
// pending vector and interrupt request.
// Optional feature macro CP0_TIMER_EN: when defined, Count/Compare and the
// timer interrupt TI are implemented by cp0_timer; otherwise registers 9/11
// read 0, writes to them are dropped and TI is 0.
// Same-cycle priority per field: exc_occur > eret > mtc0_we.
module cp0_regfile
   import cp0_pkg::*;
#(
   parameter int          COUNT_DIV  = 2,
   parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mtc0_we,
   input  logic [4:0]  mtc0_addr,
   input  logic [31:0] mtc0_wdata,
   input  logic [4:0]  mfc0_addr,
   output logic [31:0] mfc0_rdata,
   input  logic        exc_occur,
   input  logic [4:0]  exc_code,
   input  logic [31:0] exc_epc,
   input  logic        exc_bd,
   input  logic        exc_badv_we,
   input  logic [31:0] exc_badvaddr,
   input  logic        eret,
   input  logic [5:0]  hw_int,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [7:0]  cause_ip,
   output logic        int_req
);

   logic [7:0]  status_im;
   logic        status_exl;
   logic        status_ie;
   logic        cause_bd;
   logic [5:0]  cause_ip_hw;
   logic [1:0]  cause_ip_sw;
   logic [4:0]  cause_exc;
   logic [31:0] epc_q;
   logic [31:0] badvaddr_q;

   logic [31:0] count;
   logic [31:0] compare;
   logic        ti;

   logic wr_status;
   logic wr_cause;
   logic wr_epc;

   assign wr_status = mtc0_we && (mtc0_addr == CP0_STATUS);
   assign wr_cause  = mtc0_we && (mtc0_addr == CP0_CAUSE);
   assign wr_epc    = mtc0_we && (mtc0_addr == CP0_EPC);

`ifdef CP0_TIMER_EN
   cp0_timer #(
      .COUNT_DIV (COUNT_DIV)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .count_we   (mtc0_we && (mtc0_addr == CP0_COUNT)),
      .compare_we (mtc0_we && (mtc0_addr == CP0_COMPARE)),
      .wdata      (mtc0_wdata),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );
`else
   assign count   = 32'd0;
   assign compare = 32'd0;
   assign ti      = 1'b0;
`endif

   // Status: IM/IE follow MTC0; EXL is set by exceptions, cleared by ERET,
   // and only then writable by software
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status_im  <= STATUS_RST[STATUS_IM_HI:STATUS_IM_LO];
         status_exl <= STATUS_RST[STATUS_EXL];
         status_ie  <= STATUS_RST[STATUS_IE];
      end else begin
         if (wr_status) begin
            status_im <= mtc0_wdata[STATUS_IM_HI:STATUS_IM_LO];
            status_ie <= mtc0_wdata[STATUS_IE];
         end
         if (exc_occur)
            status_exl <= 1'b1;
         else if (eret)
            status_exl <= 1'b0;
         else if (wr_status)
            status_exl <= mtc0_wdata[STATUS_EXL];
      end
   end

   // Cause: hardware IP sampled every cycle, software IP via MTC0,
   // BD/ExcCode recorded on exception commit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cause_ip_hw <= '0;
         cause_ip_sw <= '0;
         cause_bd    <= 1'b0;
         cause_exc   <= '0;
      end else begin
         cause_ip_hw <= {hw_int[5] | ti, hw_int[4:0]};
         if (wr_cause)
            cause_ip_sw <= mtc0_wdata[CAUSE_IP_LO+1:CAUSE_IP_LO];
         if (exc_occur) begin
            cause_bd  <= exc_bd;
            cause_exc <= exc_code;
         end
      end
   end

   // EPC and BadVAddr; the exception commit overrides a same-cycle MTC0 EPC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         epc_q      <= '0;
         badvaddr_q <= '0;
      end else begin
         if (exc_occur)
            epc_q <= exc_epc;
         else if (wr_epc)
            epc_q <= mtc0_wdata;
         if (exc_occur && exc_badv_we)
            badvaddr_q <= exc_badvaddr;
      end
   end

   assign status_o = (STATUS_RST & STATUS_BEV_MASK)
                   | {16'd0, status_im, 6'd0, status_exl, status_ie};
   assign cause_ip = {cause_ip_hw, cause_ip_sw};
   assign cause_o  = pack_cause(cause_bd, ti, cause_ip, cause_exc);
   assign epc_o    = epc_q;
   assign int_req  = status_ie && !status_exl && |(cause_ip & status_im);

   // MFC0 read mux; unimplemented registers read 0
   always_comb begin
      mfc0_rdata = 32'd0;
      case (mfc0_addr)
         CP0_BADVADDR: mfc0_rdata = badvaddr_q;
         CP0_COUNT:    mfc0_rdata = count;
         CP0_COMPARE:  mfc0_rdata = compare;
         CP0_STATUS:   mfc0_rdata = status_o;
         CP0_CAUSE:    mfc0_rdata = cause_o;
         CP0_EPC:      mfc0_rdata = epc_q;
         default:      mfc0_rdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: a table of per-cycle vectors with
// hand-computed expectations, then hand-written reset and timer sequences.
// Timer sequences are built only when CP0_TIMER_EN is defined.
module tb_cp0_regfile;

   localparam int TB_DIV = 2;

   logic        clk;
   logic        rst;
   logic        mtc0_we;
   logic [4:0]  mtc0_addr;
   logic [31:0] mtc0_wdata;
   logic [4:0]  mfc0_addr;
   logic [31:0] mfc0_rdata;
   logic        exc_occur;
   logic [4:0]  exc_code;
   logic [31:0] exc_epc;
   logic        exc_bd;
   logic        exc_badv_we;
   logic [31:0] exc_badvaddr;
   logic        eret;
   logic [5:0]  hw_int;
   logic [31:0] status_o;
   logic [31:0] cause_o;
   logic [31:0] epc_o;
   logic [7:0]  cause_ip;
   logic        int_req;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   cp0_regfile #(
      .COUNT_DIV  (TB_DIV),
      .STATUS_RST (32'h0040_0000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mtc0_we      (mtc0_we),
      .mtc0_addr    (mtc0_addr),
      .mtc0_wdata   (mtc0_wdata),
      .mfc0_addr    (mfc0_addr),
      .mfc0_rdata   (mfc0_rdata),
      .exc_occur    (exc_occur),
      .exc_code     (exc_code),
      .exc_epc      (exc_epc),
      .exc_bd       (exc_bd),
      .exc_badv_we  (exc_badv_we),
      .exc_badvaddr (exc_badvaddr),
      .eret         (eret),
      .hw_int       (hw_int),
      .status_o     (status_o),
      .cause_o      (cause_o),
      .epc_o        (epc_o),
      .cause_ip     (cause_ip),
      .int_req      (int_req)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        mtc0_we;
      logic [4:0]  mtc0_addr;
      logic [31:0] mtc0_wdata;
      logic [4:0]  mfc0_addr;
      logic        exc_occur;
      logic [4:0]  exc_code;
      logic [31:0] exc_epc;
      logic        exc_bd;
      logic        badv_we;
      logic [31:0] badvaddr;
      logic        eret;
      logic [5:0]  hw_int;
      logic [31:0] e_status;
      logic [31:0] e_cause;
      logic [31:0] e_epc;
      logic [31:0] e_rdata;
      logic        e_int;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs[NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      mtc0_we      = 1'b0;
      mtc0_addr    = 5'd0;
      mtc0_wdata   = 32'd0;
      exc_occur    = 1'b0;
      exc_code     = 5'd0;
      exc_epc      = 32'd0;
      exc_bd       = 1'b0;
      exc_badv_we  = 1'b0;
      exc_badvaddr = 32'd0;
      eret         = 1'b0;
   endtask

   // driver: one MTC0 write, outputs settled #1 after the edge
   task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      mtc0_we    = 1'b1;
      mtc0_addr  = a;
      mtc0_wdata = d;
      @(posedge clk);
      #1;
      mtc0_we    = 1'b0;
   endtask

   task automatic apply_vec(input vec_t v);
      @(negedge clk);
      mtc0_we      = v.mtc0_we;
      mtc0_addr    = v.mtc0_addr;
      mtc0_wdata   = v.mtc0_wdata;
      mfc0_addr    = v.mfc0_addr;
      exc_occur    = v.exc_occur;
      exc_code     = v.exc_code;
      exc_epc      = v.exc_epc;
      exc_bd       = v.exc_bd;
      exc_badv_we  = v.badv_we;
      exc_badvaddr = v.badvaddr;
      eret         = v.eret;
      hw_int       = v.hw_int;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] r9;
      logic [31:0] r11;
      logic [31:0] got;
      int n;
      bit seen;

`ifdef CP0_TIMER_EN
      r9  = 32'h0000_0055;
      r11 = 32'h0000_0077;
`else
      r9  = 32'h0;
      r11 = 32'h0;
`endif
      // fields: mtc0 we/addr/wdata, mfc0 addr, exc occur/code/epc/bd/badv_we/badvaddr,
      //         eret, hw_int | expected status, cause, epc, rdata, int_req
      vecs[0]  = '{0, 5'd0,  32'h0,         5'd12, 0, 5'h00, 32'h0,         0, 0, 32'h0,    0, 6'h00,
                   32'h0040_0000, 32'h0000_0000, 32'h0,         32'h0040_0000, 0};
      vecs[1]  = '{0, 5'd0,  32'h0,         5'd8,  1, 5'h04, 32'hbfc0_0100, 1, 1, 32'h1235, 0, 6'h00,
                   32'h0040_0002, 32'h8000_0010, 32'hbfc0_0100, 32'h0000_1235, 0};
      vecs[2]  = '{0, 5'd0,  32'h0,         5'd14, 0, 5'h00, 32'h0,         0, 0, 32'h0,    1, 6'h00,
                   32'h0040_0000, 32'h8000_0010, 32'hbfc0_0100, 32'hbfc0_0100, 0};
      vecs[3]  = '{1, 5'd12, 32'h0000_ff01, 5'd13, 0, 5'h00, 32'h0,         0, 0, 32'h0,    0, 6'h01,
                   32'h0040_ff01, 32'h8000_0410, 32'hbfc0_0100, 32'h8000_0410, 1};
      vecs[4]  = '{1, 5'd12, 32'h0000_ff03, 5'd12, 0, 5'h00, 32'h0,         0, 0, 32'h0,    0, 6'h01,
                   32'h0040_ff03, 32'h8000_0410, 32'hbfc0_0100, 32'h0040_ff03, 0};
      vecs[5]  = '{1, 5'd12, 32'hffff_ffff, 5'd12, 0, 5'h00, 32'h0,         0, 0, 32'h0,    0, 6'h00,
                   32'h0040_ff03, 32'h8000_0010, 32'hbfc0_0100, 32'h0040_ff03, 0};
      vecs[6]  = '{1, 5'd13, 32'hffff_ffff, 5'd13, 0, 5'h00, 32'h0,         0, 0, 32'h0,    0, 6'h00,
                   32'h0040_ff03, 32'h8000_0310, 32'hbfc0_0100, 32'h8000_0310, 0};
      vecs[7]  = '{1, 5'd12, 32'h0000_0101, 5'd12, 0, 5'h00, 32'h0,         0, 0, 32'h0,    0, 6'h00,
                   32'h0040_0101, 32'h8000_0310, 32'hbfc0_0100, 32'h0040_0101, 1};
      vecs[8]  = '{1, 5'd14, 32'h0000_0004, 5'd14, 1, 5'h0c, 32'h8000_1000, 0, 0, 32'hffff_ffff, 1, 6'h00,
                   32'h0040_0103, 32'h0000_0330, 32'h8000_1000, 32'h8000_1000, 0};
      vecs[9]  = '{1, 5'd12, 32'h0000_0003, 5'd8,  0, 5'h00, 32'h0,         0, 0, 32'h0,    1, 6'h00,
                   32'h0040_0001, 32'h0000_0330, 32'h8000_1000, 32'h0000_1235, 0};
      vecs[10] = '{1, 5'd14, 32'h0000_0004, 5'd14, 0, 5'h00, 32'h0,         0, 0, 32'h0,    0, 6'h00,
                   32'h0040_0001, 32'h0000_0330, 32'h0000_0004, 32'h0000_0004, 0};
      vecs[11] = '{1, 5'd8,  32'hdead_beef, 5'd8,  0, 5'h00, 32'h0,         0, 0, 32'h0,    0, 6'h00,
                   32'h0040_0001, 32'h0000_0330, 32'h0000_0004, 32'h0000_1235, 0};
      vecs[12] = '{1, 5'd15, 32'h1234_5678, 5'd15, 0, 5'h00, 32'h0,         0, 0, 32'h0,    0, 6'h00,
                   32'h0040_0001, 32'h0000_0330, 32'h0000_0004, 32'h0000_0000, 0};
      vecs[13] = '{1, 5'd9,  32'h0000_0055, 5'd9,  0, 5'h00, 32'h0,         0, 0, 32'h0,    0, 6'h00,
                   32'h0040_0001, 32'h0000_0330, 32'h0000_0004, r9,            0};
      vecs[14] = '{1, 5'd11, 32'h0000_0077, 5'd11, 0, 5'h00, 32'h0,         0, 0, 32'h0,    0, 6'h00,
                   32'h0040_0001, 32'h0000_0330, 32'h0000_0004, r11,           0};
      vecs[15] = '{0, 5'd0,  32'h0,         5'd13, 0, 5'h00, 32'h0,         0, 0, 32'h0,    0, 6'h20,
                   32'h0040_0001, 32'h0000_8330, 32'h0000_0004, 32'h0000_8330, 0};
      vecs[16] = '{1, 5'd12, 32'h0000_8001, 5'd12, 0, 5'h00, 32'h0,         0, 0, 32'h0,    0, 6'h20,
                   32'h0040_8001, 32'h0000_8330, 32'h0000_0004, 32'h0040_8001, 1};
      vecs[17] = '{1, 5'd13, 32'h0000_0000, 5'd14, 1, 5'h08, 32'h0000_0100, 1, 0, 32'h0,    0, 6'h00,
                   32'h0040_8003, 32'h8000_0020, 32'h0000_0100, 32'h0000_0100, 0};

      idle_inputs();
      mfc0_addr = 5'd0;
      hw_int    = 6'd0;
      rst       = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // table-driven vectors
      for (int i = 0; i < NV; i++) begin
         apply_vec(vecs[i]);
         exp_q.push_back(vecs[i].e_rdata);
         chk($sformatf("v%0d status", i), status_o, vecs[i].e_status);
         chk($sformatf("v%0d cause", i), cause_o, vecs[i].e_cause);
         chk($sformatf("v%0d epc", i), epc_o, vecs[i].e_epc);
         chk($sformatf("v%0d cause_ip", i), {24'd0, cause_ip}, {24'd0, vecs[i].e_cause[15:8]});
         chk($sformatf("v%0d int_req", i), {31'd0, int_req}, {31'd0, vecs[i].e_int});
         chk($sformatf("v%0d mfc0", i), mfc0_rdata, exp_q.pop_front());
         idle_inputs();
      end

      // mid-cycle asynchronous reset
      @(posedge clk);
      #2;
      mfc0_addr = 5'd8;
      rst = 1'b1;
      #1;
      chk("rst status", status_o, 32'h0040_0000);
      chk("rst cause", cause_o, 32'h0);
      chk("rst epc", epc_o, 32'h0);
      chk("rst int_req", {31'd0, int_req}, 32'h0);
      chk("rst badvaddr", mfc0_rdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;

`ifdef CP0_TIMER_EN
      // Count wrap after COUNT_DIV cycles
      do_mtc0(5'd9, 32'hffff_ffff);
      mfc0_addr = 5'd9;
      chk("wrap load", mfc0_rdata, 32'hffff_ffff);
      @(posedge clk); #1;
      chk("wrap hold", mfc0_rdata, 32'hffff_ffff);
      @(posedge clk); #1;
      chk("wrap zero", mfc0_rdata, 32'h0);

      // Count reaches Compare=10 at edge 20, TI follows one edge later
      do_mtc0(5'd11, 32'd10);
      do_mtc0(5'd9, 32'd0);
      seen = 1'b0;
      n = 0;
      while (!seen && n < 100) begin
         @(posedge clk); #1;
         n++;
         seen = cause_o[30];
      end
      chk("ti latency", n, 32'd21);
      @(posedge clk); #1;
      chk("ti to ip7", {31'd0, cause_ip[7]}, 32'd1);
      do_mtc0(5'd11, 32'd50);
      chk("ti clear", {31'd0, cause_o[30]}, 32'd0);

      // Compare=0 never raises TI
      do_mtc0(5'd11, 32'd0);
      do_mtc0(5'd9, 32'd0);
      got = 32'd0;
      repeat (6) begin
         @(posedge clk); #1;
         got = got | {31'd0, cause_o[30]};
      end
      chk("compare0 no ti", got, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
